pa_arbiter: RTL and testbench

- Shares one point_add unit between NREQ independent requesters, for example several scalar-multiply sequencers.
- Each requester submits two extended-coordinate points (x, y, z, t; 256-bit).
- The arbiter grants round-robin, drives one start pulse, waits for done, latches the result and returns it to the owning requester.
- Sits between the scalar-mult controllers and the single point_add instance.

---
 rtl/pa_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pa_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_arbiter.sv
// Round-robin arbiter sharing one point_add unit between NREQ requesters.
// Optional WAIT watchdog with error response: `define PA_ARB_TIMEOUT_EN.
module pa_arbiter #(
  parameter int NREQ    = 2,
  parameter int B       = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*B-1:0] req_x1,
  input  logic [NREQ*B-1:0] req_y1,
  input  logic [NREQ*B-1:0] req_z1,
  input  logic [NREQ*B-1:0] req_t1,
  input  logic [NREQ*B-1:0] req_x2,
  input  logic [NREQ*B-1:0] req_y2,
  input  logic [NREQ*B-1:0] req_z2,
  input  logic [NREQ*B-1:0] req_t2,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [B-1:0]      rsp_x3,
  output logic [B-1:0]      rsp_y3,
  output logic [B-1:0]      rsp_z3,
  output logic [B-1:0]      rsp_t3,
  output logic              rsp_err,
  output logic              pa_start,
  output logic [B-1:0]      pa_x1,
  output logic [B-1:0]      pa_y1,
  output logic [B-1:0]      pa_z1,
  output logic [B-1:0]      pa_t1,
  output logic [B-1:0]      pa_x2,
  output logic [B-1:0]      pa_y2,
  output logic [B-1:0]      pa_z2,
  output logic [B-1:0]      pa_t2,
  input  logic              pa_done,
  input  logic [B-1:0]      pa_x3,
  input  logic [B-1:0]      pa_y3,
  input  logic [B-1:0]      pa_z3,
  input  logic [B-1:0]      pa_t3
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("pa_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, owner, gnt_idx;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic            hit;
  logic            wait_first;
  logic            done_ok;
  logic            tmo;
  logic            rsp_take;
  int              sum;

  // Rotate so bit k of rot is requester (rr_ptr + k) mod NREQ.
  assign dbl = {req_valid, req_valid};
  assign rot = NREQ'(dbl >> rr_ptr);

  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    sum     = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        sum = int'(rr_ptr) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        gnt_idx = IW'(sum);
      end
    end
  end

`ifdef PA_ARB_TIMEOUT_EN
  logic [15:0] guard_cnt;
  logic        rsp_err_q;
  assign tmo     = (state == S_WAIT) && (guard_cnt == 16'(TIMEOUT - 1));
  assign rsp_err = rsp_err_q;
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign rsp_take = (state == S_RESP) && rsp_ready[owner];

  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    case (state)
      S_IDLE:  if (hit) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // done is a level; the first WAIT cycle may still see the previous op's done
        if (!wait_first && pa_done) begin
          done_ok   = 1'b1;
          state_nxt = S_RESP;
        end else if (tmo) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  if (rsp_ready[owner]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE && hit && rst_n) ? (NREQ'(1'b1) << gnt_idx) : '0;
  assign rsp_valid = (state == S_RESP) ? (NREQ'(1'b1) << owner) : '0;
  assign pa_start  = (state == S_ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      owner      <= '0;
      wait_first <= 1'b0;
      pa_x1 <= '0; pa_y1 <= '0; pa_z1 <= '0; pa_t1 <= '0;
      pa_x2 <= '0; pa_y2 <= '0; pa_z2 <= '0; pa_t2 <= '0;
      rsp_x3 <= '0; rsp_y3 <= '0; rsp_z3 <= '0; rsp_t3 <= '0;
    end else begin
      wait_first <= (state == S_ISSUE);
      if (state == S_IDLE && hit) begin
        owner <= gnt_idx;
        pa_x1 <= req_x1[int'(gnt_idx)*B +: B];
        pa_y1 <= req_y1[int'(gnt_idx)*B +: B];
        pa_z1 <= req_z1[int'(gnt_idx)*B +: B];
        pa_t1 <= req_t1[int'(gnt_idx)*B +: B];
        pa_x2 <= req_x2[int'(gnt_idx)*B +: B];
        pa_y2 <= req_y2[int'(gnt_idx)*B +: B];
        pa_z2 <= req_z2[int'(gnt_idx)*B +: B];
        pa_t2 <= req_t2[int'(gnt_idx)*B +: B];
      end
      if (done_ok) begin
        rsp_x3 <= pa_x3; rsp_y3 <= pa_y3; rsp_z3 <= pa_z3; rsp_t3 <= pa_t3;
      end else if (tmo) begin
        rsp_x3 <= '0; rsp_y3 <= '0; rsp_z3 <= '0; rsp_t3 <= '0;
      end
      if (rsp_take) rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
  end

`ifdef PA_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)     guard_cnt <= '0;
      else if (state == S_WAIT) guard_cnt <= guard_cnt + 16'd1;
      if (tmo && !done_ok)      rsp_err_q <= 1'b1;
      else if (rsp_take)        rsp_err_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pa_arbiter.sv
// Directed bench for pa_arbiter with a latency-4 point_add stub.
module tb_pa_arbiter;
  localparam int NREQ = 2;
  localparam int B    = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*B-1:0] req_x1, req_y1, req_z1, req_t1, req_x2, req_y2, req_z2, req_t2;
  logic [B-1:0]      rsp_x3, rsp_y3, rsp_z3, rsp_t3;
  logic              rsp_err, pa_start, pa_done;
  logic [B-1:0]      pa_x1, pa_y1, pa_z1, pa_t1, pa_x2, pa_y2, pa_z2, pa_t2;
  logic [B-1:0]      pa_x3, pa_y3, pa_z3, pa_t3;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic stale_mode = 1'b0;
  logic never_done = 1'b0;
  logic [2:0] cnt;
  logic start_d;

  pa_arbiter #(.NREQ(NREQ), .B(B), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_y1(req_y1), .req_z1(req_z1), .req_t1(req_t1),
    .req_x2(req_x2), .req_y2(req_y2), .req_z2(req_z2), .req_t2(req_t2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x3(rsp_x3), .rsp_y3(rsp_y3), .rsp_z3(rsp_z3), .rsp_t3(rsp_t3),
    .rsp_err(rsp_err), .pa_start(pa_start),
    .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_z1(pa_z1), .pa_t1(pa_t1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_z2(pa_z2), .pa_t2(pa_t2),
    .pa_done(pa_done),
    .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_z3(pa_z3), .pa_t3(pa_t3)
  );

  // point_add stub: done rises 4 edges after start is sampled and stays high;
  // in stale_mode the old done is cleared one cycle later than normal.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 3'd0; start_d <= 1'b0; pa_done <= 1'b0;
      pa_x3 <= '0; pa_y3 <= '0; pa_z3 <= '0; pa_t3 <= '0;
    end else begin
      start_d <= pa_start;
      if (pa_start) cnt <= 3'd4;
      else if (cnt != 3'd0) cnt <= cnt - 3'd1;
      if (cnt == 3'd1 && !pa_start && !never_done) begin
        pa_done <= 1'b1;
        pa_x3 <= pa_x1 ^ pa_x2; pa_y3 <= pa_y1 + pa_y2;
        pa_z3 <= 1;             pa_t3 <= pa_t1 | pa_t2;
      end else if (stale_mode ? start_d : pa_start) begin
        pa_done <= 1'b0;
      end
    end
  end

  always @(negedge clk) if (pa_start) start_cnt++;

  typedef struct {
    int r;
    logic [B-1:0] x1, y1, z1, t1, x2, y2, z2, t2;
    logic [B-1:0] x3, y3, z3, t3;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [B-1:0] act, input logic [B-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int r, input vec_t v);
    req_x1[r*B +: B] = v.x1; req_y1[r*B +: B] = v.y1;
    req_z1[r*B +: B] = v.z1; req_t1[r*B +: B] = v.t1;
    req_x2[r*B +: B] = v.x2; req_y2[r*B +: B] = v.y2;
    req_z2[r*B +: B] = v.z2; req_t2[r*B +: B] = v.t2;
  endtask

  task automatic chk_rsp(input string tag, input vec_t v);
    chk({tag, "_x3"}, rsp_x3, v.x3);
    chk({tag, "_y3"}, rsp_y3, v.y3);
    chk({tag, "_z3"}, rsp_z3, v.z3);
    chk({tag, "_t3"}, rsp_t3, v.t3);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid == '0 && lat < 60) begin @(negedge clk); #1; lat++; end
  endtask

  task automatic wait_gnt();
    int t;
    t = 0;
    while (req_ready == '0 && t < 40) begin @(negedge clk); #1; t++; end
  endtask

  // One isolated operation: grant, single start pulse, 7-cycle latency, result.
  task automatic do_op(input vec_t v, input string tag);
    int s0, lat;
    @(negedge clk);
    set_ops(v.r, v);
    req_valid[v.r] = 1'b1;
    #1;
    wait_gnt();
    chk({tag, "_gnt"}, req_ready, 1 << v.r);
    s0 = start_cnt;
    @(negedge clk);
    req_valid[v.r] = 1'b0;
    #1;
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, 7);
    chk({tag, "_vld"}, rsp_valid, 1 << v.r);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_starts"}, start_cnt - s0, 1);
    chk_rsp(tag, v);
  endtask

  initial begin
    int g, rcount, last_g, lat;
    logic [B-1:0] hold_x3;

    tbl[0] = '{0, 1, 2, 3, 4, 8, 5, 1, 2, 9, 7, 1, 6};
    tbl[1] = '{1, 'hF0, 'h10, 7, 8, 'h0F, 'h20, 9, 1, 'hFF, 'h30, 1, 9};
    tbl[2] = '{0, '1, '1, 5, 0, '1, 1, 6, 0, 0, 0, 1, 0};
    tbl[3] = '{1, 'hA5, 3, 0, {1'b1, 255'd0}, 'h5A, 4, 0, 1, 'hFF, 7, 1, {1'b1, 254'd0, 1'b1}};

    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
    req_x1 = '0; req_y1 = '0; req_z1 = '0; req_t1 = '0;
    req_x2 = '0; req_y2 = '0; req_z2 = '0; req_t2 = '0;
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pa_start", pa_start, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_pa_x1", pa_x1, 0);
    chk("rst_rsp_x3", rsp_x3, 0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    stale_mode = 1'b1;
    do_op(tbl[0], "stale0");
    do_op(tbl[1], "stale1");
    stale_mode = 1'b0;

    // Contention from reset: both always valid, grants alternate every 8 cycles.
    @(negedge clk);
    rst_n = 1'b0;
    set_ops(0, tbl[0]); set_ops(1, tbl[1]);
    req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    g = 0; rcount = 0; last_g = 0;
    for (int c = 0; c < 80 && rcount < 4; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (req_ready != '0) begin
        chk($sformatf("cont_gnt%0d", g), req_ready, 1 << (g % 2));
        if (g > 0) chk($sformatf("cont_gap%0d", g), c - last_g, 8);
        last_g = c;
        g++;
      end
      if (rsp_valid != '0) begin
        chk($sformatf("cont_rsp%0d", rcount), rsp_valid, 1 << (rcount % 2));
        chk_rsp($sformatf("cont_rsp%0d", rcount), tbl[rcount % 2]);
        rcount++;
      end
    end
    chk("cont_rsp_count", rcount, 4);
    @(negedge clk);
    req_valid = 2'b00;

    // Backpressure: requester 0 result held 10 cycles, requester 1 waits.
    @(negedge clk);
    set_ops(0, tbl[0]); set_ops(1, tbl[3]);
    rsp_ready = 2'b10;
    req_valid = 2'b01;
    #1;
    wait_gnt();
    chk("bp_gnt0", req_ready, 1);
    @(negedge clk);
    req_valid = 2'b10;
    req_x1[0 +: B] = 'hDEAD;
    #1;
    wait_rsp(lat);
    chk("bp_vld", rsp_valid, 1);
    chk_rsp("bp_rsp0", tbl[0]);
    hold_x3 = rsp_x3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("bp_hold%0d", c),
          {rsp_valid, req_ready, pa_start, rsp_x3 == hold_x3}, {2'b01, 2'b00, 1'b0, 1'b1});
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    #1;
    chk("bp_release_vld", rsp_valid, 1);
    @(negedge clk); #1;
    chk("bp_gnt1", req_ready, 2);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    wait_rsp(lat);
    chk("bp_vld1", rsp_valid, 2);
    chk_rsp("bp_rsp1", tbl[3]);

    // Reset in WAIT while requester 1 owns the unit; rr_ptr returns to 0.
    do_op(tbl[0], "pre_rst");
    @(negedge clk);
    set_ops(1, tbl[1]);
    req_valid = 2'b10;
    #1;
    chk("mid_gnt1", req_ready, 2);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_outs", {req_ready, rsp_valid, pa_start, rsp_err}, 0);
    chk("mid_rst_pa_x1", pa_x1, 0);
    chk("mid_rst_pa_y2", pa_y2, 0);
    chk("mid_rst_rsp_x3", rsp_x3, 0);
    chk("mid_rst_rsp_y3", rsp_y3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", req_ready, 1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    wait_rsp(lat);
    chk("post_rst_vld", rsp_valid, 1);
    chk_rsp("post_rst", tbl[0]);

`ifdef PA_ARB_TIMEOUT_EN
    never_done = 1'b1;
    @(negedge clk);
    set_ops(0, tbl[0]);
    req_valid = 2'b01;
    #1;
    wait_gnt();
    chk("tmo_gnt", req_ready, 1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    wait_rsp(lat);
    chk("tmo_lat", lat, 22);
    chk("tmo_vld", rsp_valid, 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_x3", rsp_x3, 0);
    @(negedge clk); #1;
    chk("tmo_err_clr", rsp_err, 0);
    never_done = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
